// File: rtl/add_arb_pkg.sv
// Shared definitions for add_arb: FSM encodings, saturation constants, counter width.
// Optional feature macro: ADD_SAT_EN (saturating result on signed overflow).
package add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;
    localparam int          CNT_W   = 16;

    // Clamp value for an overflowed sum; the sign of either operand selects the rail.
    function automatic logic [31:0] sat_value(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/add_arb_cadd32.sv
// Shared 32-bit two's-complement adder with signed-overflow flag.
module cadd32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        ovf
);

    assign sum = a + b;
    // Overflow only when the operands agree in sign and the result disagrees.
    assign ovf = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/add_arb.sv
// Two-requester round-robin arbiter in front of one shared adder (IDLE/EXEC/HOLD).
// Optional feature macro: ADD_SAT_EN clamps overflowed sums to the signed rails.
module add_arb
    import add_arb_pkg::*;
#(
    parameter int FIRST_PRI = 0,
    parameter int W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_sum,
    output logic             rsp_ovf,
    output logic [CNT_W-1:0] ovf_cnt
);

    state_e             state_q, state_d;
    logic               last_q;
    logic [W-1:0]       a_q, b_q;
    logic               id_q;
    logic               rsp_id_q;
    logic [W-1:0]       rsp_sum_q;
    logic               rsp_ovf_q;
    logic [CNT_W-1:0]   ovf_cnt_q;

    logic               gnt_vld;
    logic               gnt_id;
    logic [W-1:0]       add_sum;
    logic               add_ovf;
    logic [W-1:0]       sum_fin;
    logic               rsp_fire;

    cadd32 u_add (
        .a   (a_q),
        .b   (b_q),
        .sum (add_sum),
        .ovf (add_ovf)
    );

`ifdef ADD_SAT_EN
    assign sum_fin = add_ovf ? sat_value(a_q[W-1]) : add_sum;
`else
    assign sum_fin = add_sum;
`endif

    assign rsp_fire = (state_q == HOLD) && rsp_ready;

    always_comb begin
        state_d    = state_q;
        gnt_vld    = 1'b0;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // Tie goes to whoever was not granted last; a lone requester always wins.
                if (req0_valid && req1_valid) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ~last_q;
                end else if (req0_valid) begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end else if (req1_valid) begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                req0_ready = gnt_vld && !gnt_id;
                req1_ready = gnt_vld && gnt_id;
                if (gnt_vld) state_d = EXEC;
            end
            EXEC:    state_d = HOLD;
            HOLD:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            // Pointer looks as if the other requester won last, so FIRST_PRI takes the first tie.
            last_q    <= (FIRST_PRI == 0);
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_sum_q <= '0;
            rsp_ovf_q <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_vld) begin
                last_q <= gnt_id;
                id_q   <= gnt_id;
                a_q    <= gnt_id ? req1_a : req0_a;
                b_q    <= gnt_id ? req1_b : req0_b;
            end
            if (state_q == EXEC) begin
                rsp_id_q  <= id_q;
                rsp_sum_q <= sum_fin;
                rsp_ovf_q <= add_ovf;
            end
            if (rsp_fire && rsp_ovf_q && (ovf_cnt_q != {CNT_W{1'b1}}))
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_add_arb.sv
// Self-checking bench for add_arb: vector table plus hand sequences, scoreboard on responses.
module tb_add_arb;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf;
    logic [31:0] rsp_sum;
    logic [15:0] ovf_cnt;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t tbl[8];

    add_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_ovf    (rsp_ovf),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] wrap, input logic ovf);
`ifdef ADD_SAT_EN
        if (ovf) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return wrap;
    endfunction

    function automatic exp_t mk(input logic id, input logic [31:0] a, input logic [31:0] wrap, input logic ovf);
        exp_t e;
        e.id  = id;
        e.sum = exp_sum(a, wrap, ovf);
        e.ovf = ovf;
        return e;
    endfunction

    // Scoreboard: every accepted response must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id",  32'(rsp_id),  32'(e.id));
                chk("rsp_sum", rsp_sum,      e.sum);
                chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_grant(input logic id, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) return;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
    endtask

    initial begin
        logic ok;
        int   ovf_exp;
        int   n;
        logic g;
        logic exp_rr[4];

        tbl[0] = '{1'b0, 32'd5,         32'd7,         32'h0000_000C, 1'b0};
        tbl[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        tbl[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        tbl[5] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        tbl[6] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0};
        tbl[7] = '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        exp_rr[0] = 1'b0; exp_rr[1] = 1'b1; exp_rr[2] = 1'b0; exp_rr[3] = 1'b1;

        rsp_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_rsp_sum",   rsp_sum,        32'd0);
        chk("rst_rsp_ovf",   32'(rsp_ovf),   32'd0);
        chk("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
        chk("rst_readies",   32'({req1_ready, req0_ready}), 32'd0);

        // Latency: ready pulse, EXEC cycle with nothing visible, then HOLD
        @(posedge clk); #1;
        drive(1'b0, 32'd5, 32'd7);
        @(negedge clk);
        chk("lat_gnt", 32'({req1_ready, req0_ready}), 32'd1);
        sb.push_back(mk(1'b0, 32'd5, 32'h0000_000C, 1'b0));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lat_exec_valid",  32'(rsp_valid), 32'd0);
        chk("lat_exec_ready0", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("lat_hold_valid", 32'(rsp_valid), 32'd1);
        drain();

        // Vector table, one requester at a time; ovf_cnt tracked by the bench
        ovf_exp = 0;
        foreach (tbl[i]) begin
            drive(tbl[i].id, tbl[i].a, tbl[i].b);
            wait_grant(tbl[i].id, ok);
            if (ok) sb.push_back(mk(tbl[i].id, tbl[i].a, tbl[i].sum, tbl[i].ovf));
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            drain();
            if (ok && tbl[i].ovf) ovf_exp++;
            chk($sformatf("vec%0d_ovf_cnt", i), 32'(ovf_cnt), 32'(ovf_exp));
        end

        // Round robin with both requesters valid continuously
        do_reset();
        drive(1'b0, 32'd1,  32'd2);
        drive(1'b1, 32'd10, 32'd20);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("rr_onehot", 32'(req0_ready && req1_ready), 32'd0);
                g = req1_ready;
                chk($sformatf("rr_grant%0d", n), 32'(g), 32'(exp_rr[n]));
                sb.push_back(g ? mk(1'b1, 32'd10, 32'd30, 1'b0) : mk(1'b0, 32'd1, 32'd3, 1'b0));
                n++;
            end
        end
        chk("rr_grant_count", 32'(n), 32'd4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Back-pressure in HOLD: result stable, no grants, then delivered
        rsp_ready = 1'b0;
        drive(1'b1, 32'd3, 32'd4);
        wait_grant(1'b1, ok);
        if (ok) sb.push_back(mk(1'b1, 32'd3, 32'd7, 1'b0));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drive(1'b0, 32'd100, 32'hFFFF_FFFF);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("stall_reach_hold", 32'(ok), 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("stall_valid",   32'(rsp_valid), 32'd1);
            chk("stall_sum",     rsp_sum,        32'd7);
            chk("stall_id",      32'(rsp_id),    32'd1);
            chk("stall_readies", 32'({req1_ready, req0_ready}), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("accept_no_grant", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("post_accept_grant", 32'(req0_ready), 32'd1);
        if (req0_ready) sb.push_back(mk(1'b0, 32'd100, 32'd99, 1'b0));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain();

        // Reset while in EXEC discards the operation
        drive(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_grant(1'b0, ok);
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
            chk("rst_exec_sum",   rsp_sum,        32'd0);
            chk("rst_exec_ovf",   32'(rsp_ovf),   32'd0);
            chk("rst_exec_cnt",   32'(ovf_cnt),   32'd0);
        end
        chk("rst_exec_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
